pe_sequencer: RTL and testbench
===============================

PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the source data and PE data buses.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: number of weights loaded per job.
REQ-003 SHALL have parameter ACTIVATION_SIZE, default 5: number of activations loaded per job.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for a PE status signal.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port job_start, input, 1 bit: request to start a job; sampled only in IDLE or ERROR.
REQ-008 SHALL have port job_busy, output, 1 bit: high in every state except IDLE and ERROR.
REQ-009 SHALL have port job_done, output, 1 bit: one-cycle pulse on job completion.
REQ-010 SHALL have port job_error, output, 1 bit: timeout flag, sticky.
REQ-011 SHALL have ports src_valid (input, 1), src_ready (output, 1) and src_data (input, DATA_WIDTH): the data stream carrying KERNEL_SIZE weights followed by ACTIVATION_SIZE activations.
REQ-012 SHALL have ports pe_filter_input and pe_activation_input, output, DATA_WIDTH each: data to the PE.
REQ-013 SHALL have ports pe_load_enable_weight, pe_load_enable_activation and pe_start, output, 1 bit each: PE control pulses.
REQ-014 SHALL have ports pe_load_done and pe_compute_done, input, 1 bit each: PE status signals.
REQ-015 SHALL have port iter_index, output, 8 bits: index of the current compute iteration.

Function
REQ-016 SHALL implement the states IDLE, LOAD_W, LOAD_A, WAIT_LOAD, ISSUE, WAIT_COMPUTE, DONE and ERROR.
REQ-017 SHALL set ITERATIONS = ACTIVATION_SIZE - KERNEL_SIZE + 1, which is 3 at the defaults.
REQ-018 SHALL decode src_ready from the state only: high in LOAD_W and LOAD_A, low in every other state, and never dependent on src_valid.
REQ-019 SHALL define a transfer as src_valid && src_ready on a rising clk edge; src_data is ignored when there is no transfer.
REQ-020 SHALL, on a job_start in IDLE or ERROR, clear job_error, clear iter_index and the counters, and go to LOAD_W on the next cycle.
REQ-021 SHALL ignore job_start in all other states.
REQ-022 SHALL, for each LOAD_W transfer, register src_data onto pe_filter_input and assert pe_load_enable_weight for exactly the following cycle.
REQ-023 SHALL move from LOAD_W to LOAD_A on the KERNEL_SIZE-th transfer.
REQ-024 SHALL, for each LOAD_A transfer, register src_data onto pe_activation_input and pulse pe_load_enable_activation for one cycle.
REQ-025 SHALL move from LOAD_A to WAIT_LOAD on the ACTIVATION_SIZE-th transfer.
REQ-026 SHALL hold pe_filter_input and pe_activation_input at their last values between transfers.
REQ-027 SHALL, in WAIT_LOAD, go to ISSUE on pe_load_done=1.
REQ-028 SHALL, in ISSUE, assert pe_start for exactly one cycle and go to WAIT_COMPUTE.
REQ-029 SHALL, in WAIT_COMPUTE, on pe_compute_done=1, increment iter_index and go to DONE if the new value equals ITERATIONS, otherwise back to ISSUE.
REQ-030 SHALL sample pe_compute_done only in WAIT_COMPUTE and pe_load_done only in WAIT_LOAD; either signal in any other state has no effect.
REQ-031 SHALL count wait cycles with a counter that clears on entry to WAIT_LOAD or WAIT_COMPUTE.
REQ-032 SHALL go to ERROR and set job_error=1 if the awaited status is still 0 after TIMEOUT_CYCLES cycles.
REQ-033 SHALL give priority to the status signal if it arrives in the same cycle the timeout expires.
REQ-034 SHALL, in DONE, assert job_done for one cycle and then return to IDLE; iter_index holds ITERATIONS until the next job_start.
REQ-035 SHALL keep job_error high in ERROR until the next job_start.
REQ-036 SHALL drive every output except src_ready from a register.
REQ-037 SHALL keep every pulse output 0 outside the cycle it is defined for.

Reset
REQ-038 SHALL, when reset=1, asynchronously force: state IDLE; all counters 0; iter_index 0; job_busy, job_done, job_error, src_ready, pe_load_enable_weight, pe_load_enable_activation and pe_start all 0; pe_filter_input and pe_activation_input 0.
REQ-039 SHALL, on reset asserted mid-job, abandon the job with no further PE pulses and no job_done.
REQ-040 SHALL accept job_start on the first clk edge after reset is deasserted.

Verification
REQ-041 SHALL cover nominal: job_start, source streams W=1,2,3 then A=10..14 back-to-back, PE acks promptly -> 3 weight pulses with data 1,2,3; 5 activation pulses with data 10..14; 3 pe_start pulses; iter_index 0->1->2->3; one job_done.
REQ-042 SHALL cover stalls: src_valid toggled 1,0,1,0 during loading -> load pulses only on transfers, data order kept, pe_load_enable_activation count exactly 5.
REQ-043 SHALL cover timeout: pe_compute_done never asserted, TIMEOUT_CYCLES=8 -> ERROR after 8 wait cycles, job_error=1, no job_done; a later job_start clears job_error.
REQ-044 SHALL cover spurious inputs: pe_compute_done=1 during LOAD_A, and job_start while busy -> no state change, no extra pe_start.
REQ-045 SHALL cover reset mid-job: reset in WAIT_COMPUTE at iter_index=1 -> all outputs 0 immediately; a fresh job then completes normally with 3 pe_start pulses.
REQ-046 SHALL cover the same-cycle race: pe_compute_done in the cycle the timeout expires -> iteration advances, job_error stays 0.

Source files
------------

// File: rtl/pe_sequencer.sv
// Job sequencer for a single processing element: streams weights then activations
// into the PE, then issues ITERATIONS compute passes with per-wait timeout supervision.
module pe_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE     = 3,
  parameter int ACTIVATION_SIZE = 5,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_start,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_error,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0] pe_filter_input,
  output logic [DATA_WIDTH-1:0] pe_activation_input,
  output logic                  pe_load_enable_weight,
  output logic                  pe_load_enable_activation,
  output logic                  pe_start,
  input  logic                  pe_load_done,
  input  logic                  pe_compute_done,
  output logic [7:0]            iter_index,
  output logic [2:0]            state_dbg
);

  localparam int ITERATIONS = ACTIVATION_SIZE - KERNEL_SIZE + 1;
  localparam int LOAD_MAX   = (KERNEL_SIZE > ACTIVATION_SIZE) ? KERNEL_SIZE : ACTIVATION_SIZE;
  localparam int LCW        = $clog2(LOAD_MAX + 1);
  localparam int TCW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD_W       = 3'd1,
    LOAD_A       = 3'd2,
    WAIT_LOAD    = 3'd3,
    ISSUE        = 3'd4,
    WAIT_COMPUTE = 3'd5,
    DONE         = 3'd6,
    ERROR        = 3'd7
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [LCW-1:0]   load_cnt;
  logic [TCW-1:0]   wait_cnt;
  logic             xfer;
  logic             start_job;
  logic             load_inc;
  logic             load_clr;
  logic             wait_inc;
  logic             wait_clr;
  logic             iter_inc;
  logic             go_error;
  logic             timeout_hit;

  // Source handshake: a word moves on a rising edge where src_valid && src_ready.
  // src_ready is a pure decode of the state and never looks at src_valid.
  assign src_ready   = (state == LOAD_W) || (state == LOAD_A);
  assign xfer        = src_valid && src_ready;
  assign timeout_hit = (wait_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start_job  = 1'b0;
    load_inc   = 1'b0;
    load_clr   = 1'b0;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    iter_inc   = 1'b0;
    go_error   = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (job_start) begin
          start_job  = 1'b1;
          next_state = LOAD_W;
        end
      end
      LOAD_W: begin
        if (xfer) begin
          if (load_cnt == LCW'(KERNEL_SIZE - 1)) begin
            load_clr   = 1'b1;
            next_state = LOAD_A;
          end else begin
            load_inc = 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (xfer) begin
          if (load_cnt == LCW'(ACTIVATION_SIZE - 1)) begin
            load_clr   = 1'b1;
            wait_clr   = 1'b1;
            next_state = WAIT_LOAD;
          end else begin
            load_inc = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        // The status wins over a timeout expiring in the same cycle.
        if (pe_load_done) begin
          next_state = ISSUE;
        end else if (timeout_hit) begin
          go_error   = 1'b1;
          next_state = ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ISSUE: begin
        wait_clr   = 1'b1;
        next_state = WAIT_COMPUTE;
      end
      WAIT_COMPUTE: begin
        if (pe_compute_done) begin
          iter_inc = 1'b1;
          if (iter_index + 8'd1 == 8'(ITERATIONS)) begin
            next_state = DONE;
          end else begin
            next_state = ISSUE;
          end
        end else if (timeout_hit) begin
          go_error   = 1'b1;
          next_state = ERROR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Every non-handshake output is registered from the next-state decision, so
  // pulses line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt                  <= '0;
      wait_cnt                  <= '0;
      iter_index                <= '0;
      job_busy                  <= 1'b0;
      job_done                  <= 1'b0;
      job_error                 <= 1'b0;
      pe_start                  <= 1'b0;
      pe_load_enable_weight     <= 1'b0;
      pe_load_enable_activation <= 1'b0;
      pe_filter_input           <= '0;
      pe_activation_input       <= '0;
    end else begin
      job_busy                  <= !((next_state == IDLE) || (next_state == ERROR));
      job_done                  <= (next_state == DONE);
      pe_start                  <= (next_state == ISSUE);
      pe_load_enable_weight     <= (state == LOAD_W) && xfer;
      pe_load_enable_activation <= (state == LOAD_A) && xfer;

      if ((state == LOAD_W) && xfer) begin
        pe_filter_input <= src_data;
      end
      if ((state == LOAD_A) && xfer) begin
        pe_activation_input <= src_data;
      end

      if (start_job || load_clr) begin
        load_cnt <= '0;
      end else if (load_inc) begin
        load_cnt <= load_cnt + LCW'(1);
      end

      if (start_job || wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + TCW'(1);
      end

      if (start_job) begin
        iter_index <= '0;
      end else if (iter_inc) begin
        iter_index <= iter_index + 8'd1;
      end

      if (start_job) begin
        job_error <= 1'b0;
      end else if (go_error) begin
        job_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: directed jobs push expected PE events into a
// queue, and a negedge monitor pops and compares every pulse the DUT produces.
module tb_pe_sequencer;

  localparam int DW = 16;
  localparam int EW = 19;
  localparam logic [2:0] EV_W     = 3'd1;
  localparam logic [2:0] EV_A     = 3'd2;
  localparam logic [2:0] EV_START = 3'd3;
  localparam logic [2:0] EV_DONE  = 3'd4;
  localparam logic [2:0] EV_ERR   = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_start;
  logic          job_busy;
  logic          job_done;
  logic          job_error;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic [DW-1:0] pe_filter_input;
  logic [DW-1:0] pe_activation_input;
  logic          pe_load_enable_weight;
  logic          pe_load_enable_activation;
  logic          pe_start;
  logic          pe_load_done;
  logic          pe_compute_done;
  logic [7:0]    iter_index;
  logic [2:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic          err_prev = 1'b0;

  logic [DW-1:0] w_vec [3] = '{16'd1, 16'd2, 16'd3};
  logic [DW-1:0] a_vec [5] = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14};

  pe_sequencer #(
    .DATA_WIDTH(16), .KERNEL_SIZE(3), .ACTIVATION_SIZE(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .job_start(job_start),
    .job_busy(job_busy), .job_done(job_done), .job_error(job_error),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .pe_filter_input(pe_filter_input), .pe_activation_input(pe_activation_input),
    .pe_load_enable_weight(pe_load_enable_weight),
    .pe_load_enable_activation(pe_load_enable_activation),
    .pe_start(pe_start), .pe_load_done(pe_load_done), .pe_compute_done(pe_compute_done),
    .iter_index(iter_index), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input logic [2:0] t, input logic [DW-1:0] d);
    return {t, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_pop(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event %0h with nothing expected", name, got);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(got), 32'(e));
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (pe_load_enable_weight)     mon_pop("weight pulse", ev(EV_W, pe_filter_input));
    if (pe_load_enable_activation) mon_pop("activation pulse", ev(EV_A, pe_activation_input));
    if (pe_start)                  mon_pop("pe_start pulse", ev(EV_START, {8'd0, iter_index}));
    if (job_done)                  mon_pop("job_done pulse", ev(EV_DONE, {8'd0, iter_index}));
    if (job_error && !err_prev)    mon_pop("error entry", ev(EV_ERR, {8'd0, iter_index}));
    err_prev = job_error;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit stall);
    bit ok = 1'b0;
    src_valid = 1'b1;
    src_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = src_ready;
      @(posedge clk);
      #1;
    end
    check("src transfer", 32'(ok), 32'd1);
    src_valid = 1'b0;
    if (stall) begin
      src_data = 16'hdead;
      tick();
    end
  endtask

  task automatic load_all(input bit stall, input bit spurious);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ev(EV_W, w_vec[k]));
      send(w_vec[k], stall);
    end
    if (spurious) begin
      pe_compute_done = 1'b1;
      job_start       = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ev(EV_A, a_vec[k]));
      send(a_vec[k], stall);
    end
    pe_compute_done = 1'b0;
    job_start       = 1'b0;
  endtask

  task automatic ack_load();
    pe_load_done = 1'b1;
    tick();
    pe_load_done = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pe_start;
    end
    check("pe_start seen", 32'(seen), 32'd1);
  endtask

  task automatic compute(input logic [7:0] it, input int delay, input bit last);
    exp_q.push_back(ev(EV_START, {8'd0, it}));
    wait_start();
    tick();
    repeat (delay) tick();
    if (last) exp_q.push_back(ev(EV_DONE, 16'd3));
    pe_compute_done = 1'b1;
    tick();
    pe_compute_done = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    tick();
    check({tag, " iter_index held"}, 32'(iter_index), 32'd3);
    check({tag, " job_busy idle"}, 32'(job_busy), 32'd0);
    check({tag, " job_error clear"}, 32'(job_error), 32'd0);
  endtask

  task automatic run_computes(input int delay);
    compute(8'd0, delay, 1'b0);
    compute(8'd1, delay, 1'b0);
    compute(8'd2, delay, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " job_busy"}, 32'(job_busy), 32'd0);
    check({tag, " job_done"}, 32'(job_done), 32'd0);
    check({tag, " job_error"}, 32'(job_error), 32'd0);
    check({tag, " src_ready"}, 32'(src_ready), 32'd0);
    check({tag, " pe_start"}, 32'(pe_start), 32'd0);
    check({tag, " load_w"}, 32'(pe_load_enable_weight), 32'd0);
    check({tag, " load_a"}, 32'(pe_load_enable_activation), 32'd0);
    check({tag, " filter"}, 32'(pe_filter_input), 32'd0);
    check({tag, " activation"}, 32'(pe_activation_input), 32'd0);
    check({tag, " iter_index"}, 32'(iter_index), 32'd0);
    check({tag, " state idle"}, 32'(state_dbg), 32'd0);
  endtask

  // stimulus
  initial begin
    int n;
    reset           = 1'b1;
    job_start       = 1'b0;
    src_valid       = 1'b0;
    src_data        = '0;
    pe_load_done    = 1'b0;
    pe_compute_done = 1'b0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // nominal job
    start_job();
    check("nominal busy after start", 32'(job_busy), 32'd1);
    load_all(1'b0, 1'b0);
    ack_load();
    run_computes(0);
    finish_job("nominal");

    // source stalls with junk data between transfers
    start_job();
    load_all(1'b1, 1'b0);
    ack_load();
    run_computes(2);
    finish_job("stall");

    // spurious compute_done and job_start during LOAD_A
    start_job();
    load_all(1'b0, 1'b1);
    ack_load();
    run_computes(1);
    finish_job("spurious");

    // compute timeout after 8 wait cycles
    start_job();
    load_all(1'b0, 1'b0);
    ack_load();
    exp_q.push_back(ev(EV_START, 16'd0));
    exp_q.push_back(ev(EV_ERR, 16'd0));
    wait_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (job_error) break;
    end
    check("timeout latency", 32'(n), 32'd9);
    check("timeout busy low", 32'(job_busy), 32'd0);
    check("timeout no done", 32'(job_done), 32'd0);
    tick();
    tick();
    tick();
    check("error sticky", 32'(job_error), 32'd1);
    start_job();
    check("restart clears error", 32'(job_error), 32'd0);
    check("restart busy", 32'(job_busy), 32'd1);
    load_all(1'b0, 1'b0);
    ack_load();
    run_computes(0);
    finish_job("after error");

    // compute_done in the cycle the timeout expires
    start_job();
    load_all(1'b0, 1'b0);
    ack_load();
    run_computes(7);
    finish_job("race");

    // reset in WAIT_COMPUTE at iter_index 1, then a fresh job
    start_job();
    load_all(1'b0, 1'b0);
    ack_load();
    compute(8'd0, 0, 1'b0);
    exp_q.push_back(ev(EV_START, 16'd1));
    wait_start();
    tick();
    check("midjob iter_index", 32'(iter_index), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midjob reset");
    tick();
    tick();
    reset     = 1'b0;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    check("post reset start accepted", 32'(job_busy), 32'd1);
    load_all(1'b0, 1'b0);
    ack_load();
    run_computes(0);
    finish_job("post reset");

    repeat (4) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
